// File: rtl/prog_loader.sv
// prog_loader: streams eight 9-bit words into CPU RAM, then releases the CPU.
// Define LOADER_CHECKSUM_EN to add an XOR checksum word checked before RUN.
module prog_loader (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] In_Data,
  input  logic       In_Valid,
  output logic       In_Ready,
  output logic [8:0] RAM_Write_Data,
  output logic [2:0] RAM_Write_Address,
  output logic       RAM_Write_Enable,
  output logic       CPU_Reset,
  output logic       PC_Enable,
  output logic [3:0] Word_Count,
  output logic       Busy,
  output logic       Done,
  output logic       Error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;
`endif

  localparam logic [3:0] LAST_IDX  = 4'd7;
  localparam logic [3:0] MAX_WORDS = 4'd8;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       xfer;
  logic       load_xfer;
  logic       last_word;
  logic       clear_now;

  assign xfer      = In_Valid && In_Ready;
  assign load_xfer = xfer && (state == S_LOAD);
  assign last_word = (Word_Count == LAST_IDX);
  // Counter and checksum are zeroed on entry so CLEAR shows them at 0.
  assign clear_now = (state_nxt == S_CLEAR);

`ifdef LOADER_CHECKSUM_EN
  logic [8:0] acc;
  logic       sum_ok;

  assign sum_ok = (In_Data == acc);

  // Running XOR of every word loaded since the last CLEAR
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (clear_now) begin
      acc <= '0;
    end else if (load_xfer) begin
      acc <= acc ^ In_Data;
    end
  end
`endif

  // Next-state selection; start only matters in IDLE, RUN and ERROR
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (load_xfer && last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = S_CHECK;
`else
          state_nxt = S_FLUSH;
`endif
        end
      end
      S_FLUSH: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (start) state_nxt = S_CLEAR;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) state_nxt = sum_ok ? S_RUN : S_ERROR;
      end
      S_ERROR: begin
        if (start) state_nxt = S_CLEAR;
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Accepted-word counter, saturating at eight
  always_ff @(posedge clk) begin
    if (reset) begin
      Word_Count <= '0;
    end else if (clear_now) begin
      Word_Count <= '0;
    end else if (load_xfer && (Word_Count != MAX_WORDS)) begin
      Word_Count <= Word_Count + 4'd1;
    end
  end

  // RAM write port: one-cycle strobe after each load, data/addr hold otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      RAM_Write_Enable  <= 1'b0;
      RAM_Write_Data    <= '0;
      RAM_Write_Address <= '0;
    end else begin
      RAM_Write_Enable <= load_xfer;
      if (load_xfer) begin
        RAM_Write_Data    <= In_Data;
        RAM_Write_Address <= Word_Count[2:0];
      end
    end
  end

  assign CPU_Reset = (state == S_CLEAR);
  assign PC_Enable = (state == S_RUN);
  assign Done      = (state == S_RUN);

`ifdef LOADER_CHECKSUM_EN
  assign In_Ready = (state == S_LOAD) || (state == S_CHECK);
  assign Busy     = (state == S_CLEAR) || (state == S_LOAD)
                 || (state == S_FLUSH) || (state == S_CHECK);
  assign Error    = (state == S_ERROR);
`else
  assign In_Ready = (state == S_LOAD);
  assign Busy     = (state == S_CLEAR) || (state == S_LOAD)
                 || (state == S_FLUSH);
  assign Error    = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized checks of prog_loader against a word-list model.
// Works with and without LOADER_CHECKSUM_EN defined.
`timescale 1ns/1ps
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [8:0] In_Data;
  logic       In_Valid;
  logic       In_Ready;
  logic [8:0] RAM_Write_Data;
  logic [2:0] RAM_Write_Address;
  logic       RAM_Write_Enable;
  logic       CPU_Reset;
  logic       PC_Enable;
  logic [3:0] Word_Count;
  logic       Busy;
  logic       Done;
  logic       Error;

  int total = 0;
  int bad   = 0;

  // model: words written in this load, last written data/address
  logic [8:0] words [8];
  logic [8:0] last_d;
  logic [2:0] last_a;

  // flag vector order: {In_Ready, CPU_Reset, PC_Enable, Busy, Done, Error}
  localparam logic [5:0] F_IDLE  = 6'b000000;
  localparam logic [5:0] F_CLEAR = 6'b010100;
  localparam logic [5:0] F_LOAD  = 6'b100100;
  localparam logic [5:0] F_FLUSH = 6'b000100;
  localparam logic [5:0] F_RUN   = 6'b001010;
  localparam logic [5:0] F_ERR   = 6'b000001;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .In_Data(In_Data),
    .In_Valid(In_Valid),
    .In_Ready(In_Ready),
    .RAM_Write_Data(RAM_Write_Data),
    .RAM_Write_Address(RAM_Write_Address),
    .RAM_Write_Enable(RAM_Write_Enable),
    .CPU_Reset(CPU_Reset),
    .PC_Enable(PC_Enable),
    .Word_Count(Word_Count),
    .Busy(Busy),
    .Done(Done),
    .Error(Error)
  );

  function automatic logic [5:0] flags();
    return {In_Ready, CPU_Reset, PC_Enable, Busy, Done, Error};
  endfunction

  function automatic logic [8:0] xor_words();
    logic [8:0] x = '0;
    for (int i = 0; i < 8; i++) x ^= words[i];
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    start    = 1'($urandom);
    In_Valid = 1'($urandom);
    In_Data  = 9'($urandom);
    repeat (2) tick();
    total++;
    if (flags() !== F_IDLE) begin
      bad++;
      $display("FAIL rst_flags got=%b exp=%b", flags(), F_IDLE);
    end
    total++;
    if ({RAM_Write_Enable, RAM_Write_Data, RAM_Write_Address, Word_Count} !== 17'd0) begin
      bad++;
      $display("FAIL rst_regs got=%b/%h/%h/%0d exp=0", RAM_Write_Enable,
               RAM_Write_Data, RAM_Write_Address, Word_Count);
    end
    reset    = 1'b0;
    start    = 1'b0;
    In_Valid = 1'b1;
    repeat (3) tick();
    total++;
    if ({flags(), RAM_Write_Enable, Word_Count} !== {F_IDLE, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL idle_hold got=%b/%b/%0d exp=%b/0/0", flags(),
               RAM_Write_Enable, Word_Count, F_IDLE);
    end
    last_d = '0;
    last_a = '0;
  endtask

  // pulse start from IDLE/RUN/ERROR, check the CLEAR cycle, end in LOAD
  task automatic do_start();
    start    = 1'b1;
    In_Valid = 1'($urandom);
    In_Data  = 9'($urandom);
    tick();
    start = 1'b0;
    total++;
    if ({flags(), RAM_Write_Enable, Word_Count} !== {F_CLEAR, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL clear_cycle got=%b/%b/%0d exp=%b/0/0", flags(),
               RAM_Write_Enable, Word_Count, F_CLEAR);
    end
    tick();
  endtask

  // mode 0: back-to-back base+1.., mode 1: random valid/data/start
  task automatic load_prog(input int mode, input logic [8:0] base, input int nwords);
    int  idx  = 0;
    int  cyc  = 0;
    bit  pend = 1'b0;
    while (idx < nwords && cyc < 400) begin
      total++;
      if (flags() !== F_LOAD) begin
        bad++;
        $display("FAIL load_flags idx=%0d got=%b exp=%b", idx, flags(), F_LOAD);
      end
      total++;
      if (RAM_Write_Enable !== pend) begin
        bad++;
        $display("FAIL load_wen idx=%0d got=%b exp=%b", idx, RAM_Write_Enable, pend);
      end
      total++;
      if ({RAM_Write_Data, RAM_Write_Address} !== {last_d, last_a}) begin
        bad++;
        $display("FAIL load_wdata idx=%0d got=%h@%0d exp=%h@%0d", idx,
                 RAM_Write_Data, RAM_Write_Address, last_d, last_a);
      end
      total++;
      if (Word_Count !== 4'(idx)) begin
        bad++;
        $display("FAIL load_count got=%0d exp=%0d", Word_Count, idx);
      end
      if (mode == 0) begin
        In_Valid = 1'b1;
        In_Data  = base + 9'(idx + 1);
        start    = 1'b0;
      end else begin
        In_Valid = (cyc < 20) ? 1'b0 : 1'($urandom);
        In_Data  = 9'($urandom);
        start    = ($urandom_range(0, 3) == 0);
      end
      pend = In_Valid;
      if (In_Valid) begin
        words[idx] = In_Data;
        last_d     = In_Data;
        last_a     = 3'(idx);
        idx++;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    if (idx < nwords) begin
      total++;
      bad++;
      $display("FAIL load_timeout got=%0d exp=%0d", idx, nwords);
    end
  endtask

  task automatic check_run(input string tag);
    total++;
    if ({flags(), RAM_Write_Enable, Word_Count} !== {F_RUN, 1'b0, 4'd8}) begin
      bad++;
      $display("FAIL %s got=%b/%b/%0d exp=%b/0/8", tag, flags(),
               RAM_Write_Enable, Word_Count, F_RUN);
    end
  endtask

  // called in the cycle after the 8th transfer, ends in RUN
  task automatic finish_ok();
    total++;
    if ({RAM_Write_Enable, RAM_Write_Data, RAM_Write_Address, Word_Count}
        !== {1'b1, last_d, 3'd7, 4'd8}) begin
      bad++;
      $display("FAIL final_write got=%b/%h@%0d/%0d exp=1/%h@7/8", RAM_Write_Enable,
               RAM_Write_Data, RAM_Write_Address, Word_Count, last_d);
    end
`ifdef LOADER_CHECKSUM_EN
    total++;
    if (flags() !== F_LOAD) begin
      bad++;
      $display("FAIL check_flags got=%b exp=%b", flags(), F_LOAD);
    end
    In_Valid = 1'b1;
    In_Data  = xor_words();
    start    = 1'($urandom);
`else
    total++;
    if (flags() !== F_FLUSH) begin
      bad++;
      $display("FAIL flush_flags got=%b exp=%b", flags(), F_FLUSH);
    end
    In_Valid = 1'b1;
    In_Data  = 9'($urandom);
    start    = 1'($urandom);
`endif
    tick();
    start    = 1'b0;
    In_Valid = 1'b0;
    check_run("run_entry");
    total++;
    if ({RAM_Write_Data, RAM_Write_Address} !== {last_d, last_a}) begin
      bad++;
      $display("FAIL run_hold got=%h@%0d exp=%h@%0d", RAM_Write_Data,
               RAM_Write_Address, last_d, last_a);
    end
  endtask

  task automatic test_stream();
    do_start();
    load_prog(0, 9'h100, 8);
    finish_ok();
  endtask

  task automatic test_toggle();
    do_start();
    load_prog(1, 9'h000, 8);
    finish_ok();
  endtask

  task automatic test_run_restart();
    for (int i = 0; i < 4; i++) begin
      In_Valid = 1'($urandom);
      In_Data  = 9'($urandom);
      tick();
      check_run("run_hold");
    end
    do_start();
    load_prog(1, 9'h000, 8);
    finish_ok();
  endtask

  task automatic test_reset_mid();
    do_start();
    load_prog(0, 9'h0a0, 4);
    total++;
    if ({RAM_Write_Enable, RAM_Write_Address, Word_Count} !== {1'b1, 3'd3, 4'd4}) begin
      bad++;
      $display("FAIL mid_write got=%b@%0d/%0d exp=1@3/4", RAM_Write_Enable,
               RAM_Write_Address, Word_Count);
    end
    reset    = 1'b1;
    start    = 1'b1;
    In_Valid = 1'b1;
    In_Data  = 9'h1ff;
    tick();
    reset = 1'b0;
    start = 1'b0;
    total++;
    if ({flags(), RAM_Write_Enable, RAM_Write_Data, RAM_Write_Address, Word_Count}
        !== {F_IDLE, 17'd0}) begin
      bad++;
      $display("FAIL mid_reset got=%b/%b/%h/%h/%0d exp=0", flags(), RAM_Write_Enable,
               RAM_Write_Data, RAM_Write_Address, Word_Count);
    end
    last_d = '0;
    last_a = '0;
    tick();
    total++;
    if ({flags(), RAM_Write_Enable} !== {F_IDLE, 1'b0}) begin
      bad++;
      $display("FAIL mid_idle got=%b/%b exp=%b/0", flags(), RAM_Write_Enable, F_IDLE);
    end
    do_start();
    load_prog(1, 9'h000, 8);
    finish_ok();
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_start();
    load_prog(0, 9'h000, 8);
    In_Valid = 1'b1;
    In_Data  = 9'h008;
    tick();
    In_Valid = 1'b0;
    check_run("sum_good");
    do_start();
    load_prog(0, 9'h000, 8);
    In_Valid = 1'b1;
    In_Data  = 9'h000;
    tick();
    In_Valid = 1'b0;
    total++;
    if ({flags(), RAM_Write_Enable} !== {F_ERR, 1'b0}) begin
      bad++;
      $display("FAIL sum_bad got=%b/%b exp=%b/0", flags(), RAM_Write_Enable, F_ERR);
    end
    In_Valid = 1'b1;
    tick();
    total++;
    if (flags() !== F_ERR) begin
      bad++;
      $display("FAIL err_hold got=%b exp=%b", flags(), F_ERR);
    end
    do_start();
    load_prog(1, 9'h000, 8);
    finish_ok();
  endtask
`endif

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    In_Valid = 1'b0;
    In_Data  = '0;
    last_d   = '0;
    last_a   = '0;
    test_reset();
    test_stream();
    test_toggle();
    test_run_restart();
    test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
